dma_ctrl: RTL and testbench
===========================

DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter: MAX_BURST, 4, maximum beats per burst; legal range 1..16.
REQ-002 Parameter: DATA_W, 32, data width; address width is fixed at 32.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 DMAEN  in  1  transfer enable, driven by the DMA config slave.
REQ-006 DMASRC / DMADST  in  32 each  source and destination byte addresses (word aligned).
REQ-007 DMALEN  in  32  transfer length in 32-bit words.
REQ-008 M_ARADDR / M_ARLEN / M_ARVALID  out  32/4/1  read-address channel.
REQ-009 M_ARREADY  in  1  read-address accept.
REQ-010 M_RDATA / M_RRESP / M_RLAST / M_RVALID  in  DATA_W/2/1/1  read-data channel.
REQ-011 M_RREADY  out  1  read-data accept.
REQ-012 M_AWADDR / M_AWLEN / M_AWVALID  out  32/4/1  write-address channel.
REQ-013 M_AWREADY  in  1  write-address accept.
REQ-014 M_WDATA / M_WLAST / M_WVALID  out  DATA_W/1/1  write-data channel; strobe is all-ones and is not a port.
REQ-015 M_WREADY  in  1  write-data accept.
REQ-016 M_BRESP / M_BVALID  in  2/1  write response.
REQ-017 M_BREADY  out  1  write-response accept.
REQ-018 DMA_INTERRUPT  out  1  transfer complete, level.
REQ-019 DMA_ERR  out  1  sticky error flag.

Function
REQ-020 FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
REQ-021 Start: in IDLE with DMAEN=1, latch DMASRC, DMADST and DMALEN into src_ptr, dst_ptr and remain, clear DMA_ERR, then go to RADDR.
REQ-022 DMALEN=0: go directly from IDLE to DONE; no bus activity.
REQ-023 Burst size: beats = min(remain, MAX_BURST); ARLEN = AWLEN = beats-1.
REQ-024 RADDR: ARVALID=1 with ARADDR=src_ptr; on ARVALID&ARREADY go to RDATA. ARVALID and ARADDR stay stable until accepted.
REQ-025 RDATA: RREADY=1; each accepted beat is written into a MAX_BURST-entry buffer at an index counted from 0.
REQ-026 RDATA exits on the beat with RLAST=1 or on the beats-th beat, whichever comes first; next state is WADDR.
REQ-027 WADDR: AWVALID=1 with AWADDR=dst_ptr; on AWVALID&AWREADY go to WDATA.
REQ-028 WDATA: WVALID=1 and WDATA=buffer[idx]; WLAST=1 when idx=beats-1; idx advances only on WVALID&WREADY.
REQ-029 WDATA goes to WRESP after the WLAST handshake.
REQ-030 WRESP: BREADY=1; on BVALID, update src_ptr+=4*beats, dst_ptr+=4*beats, remain-=beats.
REQ-031 WRESP next state: DONE if remain reaches 0; otherwise RADDR.
REQ-032 Error: RRESP!=0 on any accepted beat, or BRESP!=0, sets DMA_ERR. A read error skips to DONE when the read burst completes; a write error goes to DONE from WRESP.
REQ-033 DMA_INTERRUPT=1 exactly while in DONE.
REQ-034 DONE goes to IDLE when DMAEN=0.
REQ-035 DMAEN deasserted mid-transfer: the current read/write burst pair completes, including B, then the FSM goes to IDLE with no interrupt.
REQ-036 VALID outputs depend only on state, never combinationally on READY inputs; RREADY and BREADY likewise.
REQ-037 Pointer arithmetic is modulo 2^32; wrap-around is not flagged.
REQ-038 Only one outstanding transaction is allowed; read and write phases never overlap.

Reset
REQ-039 rst=0 forces: IDLE; all VALID/READY outputs 0; DMA_INTERRUPT=0; DMA_ERR=0; pointers, remain and indices 0.
REQ-040 Reset asserted mid-burst aborts immediately; no handshake is completed afterward.

Verification
REQ-041 SRC=0x1000, DST=0x2000, LEN=4, memory has zero wait states -> one 4-beat read and one 4-beat write (ARLEN=AWLEN=3); data matches; DMA_INTERRUPT=1 until DMAEN=0.
REQ-042 LEN=10, MAX_BURST=4 -> bursts of 4, 4, 2 at SRC 0x1000/0x1010/0x1020 and DST 0x2000/0x2010/0x2020; last ARLEN=1.
REQ-043 LEN=0 with DMAEN=1 -> DONE within 2 cycles; ARVALID never asserted.
REQ-044 Random READY/VALID stalls (0-5 cycles) -> ARADDR/AWADDR/WDATA held stable while stalled; final data correct.
REQ-045 BRESP=2'b10 on the second burst of LEN=8 -> DMA_ERR=1, DONE entered, no third AR issued.
REQ-046 DMAEN dropped during the RDATA of burst 1 -> burst 1 write and B complete, then IDLE; DMA_INTERRUPT stays 0.

Source files
------------

// File: rtl/dma_ctrl.sv
// Single-channel DMA engine: copies DMALEN words from DMASRC to DMADST using
// read bursts into a local buffer followed by matching write bursts.
module dma_ctrl #(
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DMAEN,
  input  logic [31:0]       DMASRC,
  input  logic [31:0]       DMADST,
  input  logic [31:0]       DMALEN,
  output logic [31:0]       M_ARADDR,
  output logic [3:0]        M_ARLEN,
  output logic              M_ARVALID,
  input  logic              M_ARREADY,
  input  logic [DATA_W-1:0] M_RDATA,
  input  logic [1:0]        M_RRESP,
  input  logic              M_RLAST,
  input  logic              M_RVALID,
  output logic              M_RREADY,
  output logic [31:0]       M_AWADDR,
  output logic [3:0]        M_AWLEN,
  output logic              M_AWVALID,
  input  logic              M_AWREADY,
  output logic [DATA_W-1:0] M_WDATA,
  output logic              M_WLAST,
  output logic              M_WVALID,
  input  logic              M_WREADY,
  input  logic [1:0]        M_BRESP,
  input  logic              M_BVALID,
  output logic              M_BREADY,
  output logic              DMA_INTERRUPT,
  output logic              DMA_ERR,
  output logic [2:0]        fsm_state
);

  // Handshakes: a beat transfers on the rising edge where VALID and READY are
  // both high; every VALID and READY driven here is a function of state only.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t            state, state_nx;
  logic [31:0]       src_ptr, dst_ptr, remain;
  logic [IW-1:0]     idx;
  logic              rd_err, stop, err;
  logic [DATA_W-1:0] buf_mem [MAX_BURST];

  logic [3:0]        beats_m1;
  logic [31:0]       beats, step;
  logic              last_idx, r_hs, r_end, rd_bad, w_hs;

  always_comb begin
    if (remain >= 32'(MAX_BURST)) beats_m1 = 4'(MAX_BURST - 1);
    else                          beats_m1 = remain[3:0] - 4'd1;
  end

  assign beats    = {28'd0, beats_m1} + 32'd1;
  assign step     = {26'd0, beats_m1, 2'b00} + 32'd4;
  assign last_idx = (idx == beats_m1[IW-1:0]);
  assign r_hs     = (state == RDATA) && M_RVALID;
  assign r_end    = r_hs && (M_RLAST || last_idx);
  assign rd_bad   = r_hs && (M_RRESP != 2'b00);
  assign w_hs     = (state == WDATA) && M_WREADY;

  assign M_ARADDR  = src_ptr;
  assign M_AWADDR  = dst_ptr;
  assign M_ARLEN   = beats_m1;
  assign M_AWLEN   = beats_m1;
  assign M_WDATA   = buf_mem[idx];
  assign DMA_ERR   = err;
  assign fsm_state = state;

  always_comb begin
    state_nx      = state;
    M_ARVALID     = 1'b0;
    M_RREADY      = 1'b0;
    M_AWVALID     = 1'b0;
    M_WVALID      = 1'b0;
    M_WLAST       = 1'b0;
    M_BREADY      = 1'b0;
    DMA_INTERRUPT = 1'b0;
    case (state)
      IDLE: if (DMAEN) state_nx = (DMALEN == 32'd0) ? DONE : RADDR;
      RADDR: begin
        M_ARVALID = 1'b1;
        if (M_ARREADY) state_nx = RDATA;
      end
      RDATA: begin
        M_RREADY = 1'b1;
        if (r_end) state_nx = (rd_err || rd_bad) ? DONE : WADDR;
      end
      WADDR: begin
        M_AWVALID = 1'b1;
        if (M_AWREADY) state_nx = WDATA;
      end
      WDATA: begin
        M_WVALID = 1'b1;
        M_WLAST  = last_idx;
        if (w_hs && last_idx) state_nx = WRESP;
      end
      WRESP: begin
        M_BREADY = 1'b1;
        if (M_BVALID) begin
          // A write error outranks a pending stop so software still sees DONE.
          if (M_BRESP != 2'b00)    state_nx = DONE;
          else if (stop)           state_nx = IDLE;
          else if (remain == beats) state_nx = DONE;
          else                     state_nx = RADDR;
        end
      end
      DONE: begin
        DMA_INTERRUPT = 1'b1;
        if (!DMAEN) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      src_ptr <= 32'd0;
      dst_ptr <= 32'd0;
      remain  <= 32'd0;
      idx     <= '0;
      rd_err  <= 1'b0;
      stop    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (DMAEN) begin
          src_ptr <= DMASRC;
          dst_ptr <= DMADST;
          remain  <= DMALEN;
          err     <= 1'b0;
          stop    <= 1'b0;
        end
        RADDR: if (M_ARREADY) begin
          idx    <= '0;
          rd_err <= 1'b0;
        end
        RDATA: if (r_hs) begin
          idx <= r_end ? '0 : idx + 1'b1;
          if (rd_bad) begin
            rd_err <= 1'b1;
            err    <= 1'b1;
          end
        end
        WDATA: if (w_hs) idx <= last_idx ? '0 : idx + 1'b1;
        WRESP: if (M_BVALID) begin
          src_ptr <= src_ptr + step;
          dst_ptr <= dst_ptr + step;
          remain  <= remain - beats;
          if (M_BRESP != 2'b00) err <= 1'b1;
        end
        default: ;
      endcase
      // Enable dropped mid-transfer: finish the current burst pair, then stop.
      if (!DMAEN && state != IDLE && state != DONE) stop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_hs) buf_mem[idx] <= M_RDATA;
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: a stalling memory slave records every burst and
// write beat, and the main sequence compares them against hand-listed bursts.
module tb_dma_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic        clk, rst;
  logic        DMAEN;
  logic [31:0] DMASRC, DMADST, DMALEN;
  logic [31:0] M_ARADDR, M_AWADDR, M_RDATA, M_WDATA;
  logic [3:0]  M_ARLEN, M_AWLEN;
  logic        M_ARVALID, M_ARREADY, M_RLAST, M_RVALID, M_RREADY;
  logic [1:0]  M_RRESP, M_BRESP;
  logic        M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY;
  logic        M_BVALID, M_BREADY, DMA_INTERRUPT, DMA_ERR;
  logic [2:0]  fsm_state;

  dma_ctrl #(.MAX_BURST(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .DMAEN(DMAEN),
    .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RVALID(M_RVALID),
    .M_RREADY(M_RREADY),
    .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .DMA_INTERRUPT(DMA_INTERRUPT), .DMA_ERR(DMA_ERR), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
  end

  int checks = 0;
  int failures = 0;

  // slave-side records (written only by the slave processes)
  logic [35:0] got_ar_q[$];
  logic [35:0] got_aw_q[$];
  logic [31:0] got_w_q[$];
  int hold_viol = 0;
  int wlast_err = 0;
  int b_cnt = 0;
  int arv_cycles = 0;
  int irq_cycles = 0;

  // main-side expectations and slave knobs
  logic [35:0] exp_ar_q[$];
  logic [35:0] exp_aw_q[$];
  logic [31:0] exp_q[$];
  int unsigned max_stall = 0;
  int bresp_at = -1;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (M_ARVALID) arv_cycles <= arv_cycles + 1;
    if (DMA_INTERRUPT) irq_cycles <= irq_cycles + 1;
  end

  // read slave: AR acceptance after a random stall, then len+1 beats with gaps
  initial begin : rd_slave
    logic [31:0] a;
    logic [3:0]  l;
    int          tries;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00; M_RLAST = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && M_ARVALID) begin
        a = M_ARADDR;
        l = M_ARLEN;
        repeat ($urandom_range(0, max_stall)) begin
          @(negedge clk);
          if (M_ARADDR !== a || M_ARLEN !== l || M_ARVALID !== 1'b1) hold_viol++;
        end
        M_ARREADY = 1'b1;
        @(negedge clk);
        M_ARREADY = 1'b0;
        got_ar_q.push_back({l, a});
        for (int b = 0; b <= int'(l); b++) begin
          repeat ($urandom_range(0, max_stall)) @(negedge clk);
          M_RVALID = 1'b1;
          M_RDATA  = pat(a + 32'(4 * b));
          M_RLAST  = (b == int'(l));
          tries = 0;
          while (M_RREADY !== 1'b1 && tries < 100) begin
            @(negedge clk);
            tries++;
          end
          @(negedge clk);
          M_RVALID = 1'b0;
          M_RLAST  = 1'b0;
        end
      end
    end
  end

  // write slave: AW, W beats with WREADY stalls, then B (error on bresp_at)
  initial begin : wr_slave
    logic [31:0] a, d;
    logic [3:0]  l;
    logic        last;
    int          tries;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (rst && M_AWVALID) begin
        a = M_AWADDR;
        l = M_AWLEN;
        repeat ($urandom_range(0, max_stall)) begin
          @(negedge clk);
          if (M_AWADDR !== a || M_AWLEN !== l || M_AWVALID !== 1'b1) hold_viol++;
        end
        M_AWREADY = 1'b1;
        @(negedge clk);
        M_AWREADY = 1'b0;
        got_aw_q.push_back({l, a});
        for (int b = 0; b <= int'(l); b++) begin
          tries = 0;
          while (M_WVALID !== 1'b1 && tries < 100) begin
            @(negedge clk);
            tries++;
          end
          d    = M_WDATA;
          last = M_WLAST;
          repeat ($urandom_range(0, max_stall)) begin
            @(negedge clk);
            if (M_WDATA !== d || M_WLAST !== last || M_WVALID !== 1'b1) hold_viol++;
          end
          M_WREADY = 1'b1;
          got_w_q.push_back(d);
          if (last !== (b == int'(l))) wlast_err++;
          @(negedge clk);
          M_WREADY = 1'b0;
        end
        repeat ($urandom_range(0, max_stall)) @(negedge clk);
        M_BVALID = 1'b1;
        M_BRESP  = (b_cnt == bresp_at) ? 2'b10 : 2'b00;
        tries = 0;
        while (M_BREADY !== 1'b1 && tries < 100) begin
          @(negedge clk);
          tries++;
        end
        @(negedge clk);
        M_BVALID = 1'b0;
        M_BRESP  = 2'b00;
        b_cnt++;
      end
    end
  end

  // driver tasks
  task automatic exp_burst(input logic [3:0] len, input logic [31:0] ar, input logic [31:0] aw);
    exp_ar_q.push_back({len, ar});
    exp_aw_q.push_back({len, aw});
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(pat(ar + 32'(4 * i)));
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    DMASRC = s;
    DMADST = d;
    DMALEN = l;
    DMAEN  = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (fsm_state !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(fsm_state), 64'(st));
  endtask

  task automatic check_sb(input string tag, input int ar0, input int aw0, input int w0);
    check({tag, "_ar_n"}, 64'(got_ar_q.size() - ar0), 64'(exp_ar_q.size()));
    for (int i = 0; i < exp_ar_q.size(); i++)
      if (ar0 + i < got_ar_q.size()) check({tag, "_ar"}, 64'(got_ar_q[ar0 + i]), 64'(exp_ar_q[i]));
    check({tag, "_aw_n"}, 64'(got_aw_q.size() - aw0), 64'(exp_aw_q.size()));
    for (int i = 0; i < exp_aw_q.size(); i++)
      if (aw0 + i < got_aw_q.size()) check({tag, "_aw"}, 64'(got_aw_q[aw0 + i]), 64'(exp_aw_q[i]));
    check({tag, "_w_n"}, 64'(got_w_q.size() - w0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (w0 + i < got_w_q.size()) check({tag, "_wdata"}, 64'(got_w_q[w0 + i]), 64'(exp_q[i]));
    exp_ar_q.delete();
    exp_aw_q.delete();
    exp_q.delete();
  endtask

  task automatic finish_idle(input string tag);
    DMAEN = 1'b0;
    wait_state(S_IDLE, 5, {tag, "_idle"});
    check({tag, "_irq_off"}, 64'(DMA_INTERRUPT), 64'd0);
  endtask

  initial begin : main
    int ar0, aw0, w0, hv0, wl0, arv0, irq0;
    DMAEN = 1'b0; DMASRC = '0; DMADST = '0; DMALEN = '0;

    // reset state
    @(negedge clk);
    check("rst_state", 64'(fsm_state), 64'(S_IDLE));
    check("rst_valids", 64'({M_ARVALID, M_AWVALID, M_WVALID}), 64'd0);
    check("rst_readys", 64'({M_RREADY, M_BREADY}), 64'd0);
    check("rst_irq_err", 64'({DMA_INTERRUPT, DMA_ERR}), 64'd0);
    check("rst_addrs", 64'({M_ARADDR, M_AWADDR}), 64'd0);
    while (rst !== 1'b1) @(negedge clk);
    @(negedge clk);

    // single 4-word burst, zero wait states
    ar0 = got_ar_q.size(); aw0 = got_aw_q.size(); w0 = got_w_q.size();
    exp_burst(4'd3, 32'h1000, 32'h2000);
    start_xfer(32'h1000, 32'h2000, 32'd4);
    wait_state(S_DONE, 400, "t1_done");
    check("t1_irq", 64'(DMA_INTERRUPT), 64'd1);
    check("t1_err", 64'(DMA_ERR), 64'd0);
    check_sb("t1", ar0, aw0, w0);
    repeat (3) @(negedge clk);
    check("t1_irq_hold", 64'(DMA_INTERRUPT), 64'd1);
    finish_idle("t1");

    // 10 words split 4/4/2
    ar0 = got_ar_q.size(); aw0 = got_aw_q.size(); w0 = got_w_q.size();
    exp_burst(4'd3, 32'h1000, 32'h2000);
    exp_burst(4'd3, 32'h1010, 32'h2010);
    exp_burst(4'd1, 32'h1020, 32'h2020);
    start_xfer(32'h1000, 32'h2000, 32'd10);
    wait_state(S_DONE, 800, "t2_done");
    check_sb("t2", ar0, aw0, w0);
    finish_idle("t2");

    // zero length: straight to DONE, no AR
    arv0 = arv_cycles;
    start_xfer(32'h1000, 32'h2000, 32'd0);
    wait_state(S_DONE, 2, "t3_done");
    check("t3_irq", 64'(DMA_INTERRUPT), 64'd1);
    repeat (2) @(negedge clk);
    check("t3_no_ar", 64'(arv_cycles - arv0), 64'd0);
    finish_idle("t3");

    // random stalls on every channel, 7 words
    max_stall = 5;
    ar0 = got_ar_q.size(); aw0 = got_aw_q.size(); w0 = got_w_q.size();
    hv0 = hold_viol; wl0 = wlast_err;
    exp_burst(4'd3, 32'h3000, 32'h5000);
    exp_burst(4'd2, 32'h3010, 32'h5010);
    start_xfer(32'h3000, 32'h5000, 32'd7);
    wait_state(S_DONE, 2000, "t4_done");
    check_sb("t4", ar0, aw0, w0);
    check("t4_hold", 64'(hold_viol - hv0), 64'd0);
    check("t4_wlast", 64'(wlast_err - wl0), 64'd0);
    finish_idle("t4");

    // write error on the second burst of 8 words
    max_stall = 2;
    ar0 = got_ar_q.size(); aw0 = got_aw_q.size(); w0 = got_w_q.size();
    bresp_at = b_cnt + 1;
    exp_burst(4'd3, 32'h4000, 32'h6000);
    exp_burst(4'd3, 32'h4010, 32'h6010);
    start_xfer(32'h4000, 32'h6000, 32'd8);
    wait_state(S_DONE, 2000, "t5_done");
    check("t5_err", 64'(DMA_ERR), 64'd1);
    repeat (5) @(negedge clk);
    check_sb("t5", ar0, aw0, w0);
    finish_idle("t5");
    check("t5_err_sticky", 64'(DMA_ERR), 64'd1);
    bresp_at = -1;

    // enable dropped during the first read burst
    max_stall = 3;
    ar0 = got_ar_q.size(); aw0 = got_aw_q.size(); w0 = got_w_q.size();
    irq0 = irq_cycles;
    exp_burst(4'd3, 32'h7000, 32'h8000);
    start_xfer(32'h7000, 32'h8000, 32'd8);
    wait_state(S_RDATA, 200, "t6_rdata");
    check("t6_err_clr", 64'(DMA_ERR), 64'd0);
    DMAEN = 1'b0;
    @(negedge clk);
    wait_state(S_IDLE, 2000, "t6_idle");
    repeat (5) @(negedge clk);
    check("t6_stay_idle", 64'(fsm_state), 64'(S_IDLE));
    check("t6_no_irq", 64'(irq_cycles - irq0), 64'd0);
    check_sb("t6", ar0, aw0, w0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
